// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/sequencing controller.
// FSM encodings and state width used by pipeline_ctrl and its debug port.
package pipeline_ctrl_pkg;

    localparam int CTRL_STATE_W = 2;

    typedef enum logic [CTRL_STATE_W-1:0] {
        CTRL_RUN      = 2'd0,
        CTRL_MEM_WAIT = 2'd1,
        CTRL_FLUSH    = 2'd2,
        CTRL_ILLEGAL  = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational load-use comparator: the ID instruction reads a register
// that the load currently in EX has not yet written back.
module pipeline_ctrl_hazard_detect #(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_rs_read_en,
    input  logic                  id_rt_read_en,
    input  logic                  ex_mem_read_en,
    input  logic [REG_ADDR_W-1:0] ex_reg_write_addr,
    output logic                  lu
);

    logic rs_hit_s;
    logic rt_hit_s;
    logic dest_live_s;

    // $0 is hardwired to zero, so a load targeting it never creates a hazard
    assign dest_live_s = ex_mem_read_en && (ex_reg_write_addr != {REG_ADDR_W{1'b0}});
    assign rs_hit_s    = id_rs_read_en && (id_rs == ex_reg_write_addr);
    assign rt_hit_s    = id_rt_read_en && (id_rt == ex_reg_write_addr);
    assign lu          = dest_live_s && (rs_hit_s || rt_hit_s);

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: load-use stalls,
// redirect squashing and memory waits. Optional perf counters: PIPE_PERF_CNT_EN.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W     = 5,
    parameter int BRANCH_PENALTY = 2,
    parameter int MAX_MEM_WAIT   = 15
`ifdef PIPE_PERF_CNT_EN
    ,
    parameter int CNT_W          = 32
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [REG_ADDR_W-1:0]   id_rs,
    input  logic [REG_ADDR_W-1:0]   id_rt,
    input  logic                    id_rs_read_en,
    input  logic                    id_rt_read_en,
    input  logic                    ex_mem_read_en,
    input  logic [REG_ADDR_W-1:0]   ex_reg_write_addr,
    input  logic                    ex_redirect,
    input  logic                    mem_req,
    input  logic                    mem_ready,
    output logic                    stall_if,
    output logic                    stall_id,
    output logic                    stall_ex,
    output logic                    stall_mem,
    output logic                    bubble_id,
    output logic                    bubble_ex,
    output logic                    bubble_wb,
    output logic                    mem_timeout,
    output logic [CTRL_STATE_W-1:0] ctrl_state
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]        perf_lu_stalls,
    output logic [CNT_W-1:0]        perf_flush_cycles,
    output logic [CNT_W-1:0]        perf_mem_wait_cycles
`endif
);

    localparam int                WAIT_W     = $clog2(MAX_MEM_WAIT + 1);
    localparam logic [1:0]        FLUSH_LOAD = 2'(BRANCH_PENALTY - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX   = WAIT_W'(MAX_MEM_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);

    ctrl_state_e       state_r;
    ctrl_state_e       state_nxt_s;
    ctrl_state_e       ret_state_r;
    ctrl_state_e       ret_state_nxt_s;
    logic [1:0]        flush_cnt_r;
    logic [1:0]        flush_cnt_nxt_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [WAIT_W-1:0] wait_cnt_nxt_s;
    logic              mem_timeout_r;
    logic              lu_s;
    logic              mem_stall_s;
    logic              lu_stall_s;
    logic              sq_id_s;
    logic              sq_ex_s;

    pipeline_ctrl_hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard_detect (
        .id_rs             (id_rs),
        .id_rt             (id_rt),
        .id_rs_read_en     (id_rs_read_en),
        .id_rt_read_en     (id_rt_read_en),
        .ex_mem_read_en    (ex_mem_read_en),
        .ex_reg_write_addr (ex_reg_write_addr),
        .lu                (lu_s)
    );

    // Next-state and per-cycle event decode; memory wait outranks redirect outranks load-use
    always_comb begin
        state_nxt_s     = state_r;
        ret_state_nxt_s = ret_state_r;
        flush_cnt_nxt_s = flush_cnt_r;
        wait_cnt_nxt_s  = wait_cnt_r;
        mem_stall_s     = 1'b0;
        lu_stall_s      = 1'b0;
        sq_id_s         = 1'b0;
        sq_ex_s         = 1'b0;
        case (state_r)
            CTRL_RUN, CTRL_FLUSH: begin
                if (mem_req && !mem_ready) begin
                    mem_stall_s     = 1'b1;
                    wait_cnt_nxt_s  = WAIT_ONE;
                    ret_state_nxt_s = state_r;
                    state_nxt_s     = CTRL_MEM_WAIT;
                end else if (ex_redirect) begin
                    sq_id_s         = 1'b1;
                    sq_ex_s         = 1'b1;
                    flush_cnt_nxt_s = FLUSH_LOAD;
                    if (FLUSH_LOAD != 2'd0) begin
                        state_nxt_s = CTRL_FLUSH;
                    end else begin
                        state_nxt_s = CTRL_RUN;
                    end
                end else if (state_r == CTRL_FLUSH) begin
                    // Squashed ID instruction cannot cause a load-use stall
                    sq_id_s = 1'b1;
                    if (flush_cnt_r <= 2'd1) begin
                        flush_cnt_nxt_s = 2'd0;
                        state_nxt_s     = CTRL_RUN;
                    end else begin
                        flush_cnt_nxt_s = flush_cnt_r - 2'd1;
                        state_nxt_s     = CTRL_FLUSH;
                    end
                end else if (lu_s) begin
                    lu_stall_s = 1'b1;
                end else begin
                    state_nxt_s = CTRL_RUN;
                end
            end
            CTRL_MEM_WAIT: begin
                mem_stall_s = 1'b1;
                if (mem_ready) begin
                    wait_cnt_nxt_s = {WAIT_W{1'b0}};
                    state_nxt_s    = ret_state_r;
                end else if (wait_cnt_r != WAIT_MAX) begin
                    wait_cnt_nxt_s = wait_cnt_r + WAIT_ONE;
                end else begin
                    wait_cnt_nxt_s = wait_cnt_r;
                end
            end
            default: begin
                state_nxt_s     = CTRL_RUN;
                ret_state_nxt_s = CTRL_RUN;
                flush_cnt_nxt_s = 2'd0;
                wait_cnt_nxt_s  = {WAIT_W{1'b0}};
            end
        endcase
    end

    // State, counters and the sticky timeout flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= CTRL_RUN;
            ret_state_r   <= CTRL_RUN;
            flush_cnt_r   <= 2'd0;
            wait_cnt_r    <= {WAIT_W{1'b0}};
            mem_timeout_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            ret_state_r   <= ret_state_nxt_s;
            flush_cnt_r   <= flush_cnt_nxt_s;
            wait_cnt_r    <= wait_cnt_nxt_s;
            mem_timeout_r <= mem_timeout_r || (wait_cnt_nxt_s == WAIT_MAX);
        end
    end

    // Reset holds the stage registers loading NOPs so the pipe comes up flushed
    assign stall_if    = rst && (mem_stall_s || lu_stall_s);
    assign stall_id    = rst && (mem_stall_s || lu_stall_s);
    assign stall_ex    = rst && mem_stall_s;
    assign stall_mem   = rst && mem_stall_s;
    assign bubble_id   = !rst || sq_id_s;
    assign bubble_ex   = !rst || sq_ex_s || lu_stall_s;
    assign bubble_wb   = !rst || mem_stall_s;
    assign mem_timeout = mem_timeout_r;
    assign ctrl_state  = state_r;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] perf_lu_r;
    logic [CNT_W-1:0] perf_flush_r;
    logic [CNT_W-1:0] perf_mem_r;

    // Free-running event counters, wrapping naturally at 2^CNT_W
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_lu_r    <= {CNT_W{1'b0}};
            perf_flush_r <= {CNT_W{1'b0}};
            perf_mem_r   <= {CNT_W{1'b0}};
        end else begin
            perf_lu_r    <= perf_lu_r + CNT_W'(lu_stall_s);
            perf_flush_r <= perf_flush_r + CNT_W'(state_r == CTRL_FLUSH);
            perf_mem_r   <= perf_mem_r + CNT_W'(mem_stall_s);
        end
    end

    assign perf_lu_stalls       = perf_lu_r;
    assign perf_flush_cycles    = perf_flush_r;
    assign perf_mem_wait_cycles = perf_mem_r;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios followed by random
// traffic, compared every cycle against an event-level reference model.
module tb_pipeline_ctrl;

    localparam int RA_W = 5;
    localparam int PEN  = 2;
    localparam int MAXW = 15;

    logic            clk = 1'b0;
    logic            rst;
    logic [RA_W-1:0] id_rs, id_rt, ex_reg_write_addr;
    logic            id_rs_read_en, id_rt_read_en, ex_mem_read_en;
    logic            ex_redirect, mem_req, mem_ready;
    logic            stall_if, stall_id, stall_ex, stall_mem;
    logic            bubble_id, bubble_ex, bubble_wb, mem_timeout;
    logic [1:0]      ctrl_state;

    int checks   = 0;
    int failures = 0;

    // reference model: pending wait, remaining squash cycles, low-ready count, sticky flag
    bit m_wait;
    int m_flush;
    int m_low;
    bit m_to;

    always #5 clk = ~clk;

    pipeline_ctrl #(
        .REG_ADDR_W     (RA_W),
        .BRANCH_PENALTY (PEN),
        .MAX_MEM_WAIT   (MAXW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .id_rs             (id_rs),
        .id_rt             (id_rt),
        .id_rs_read_en     (id_rs_read_en),
        .id_rt_read_en     (id_rt_read_en),
        .ex_mem_read_en    (ex_mem_read_en),
        .ex_reg_write_addr (ex_reg_write_addr),
        .ex_redirect       (ex_redirect),
        .mem_req           (mem_req),
        .mem_ready         (mem_ready),
        .stall_if          (stall_if),
        .stall_id          (stall_id),
        .stall_ex          (stall_ex),
        .stall_mem         (stall_mem),
        .bubble_id         (bubble_id),
        .bubble_ex         (bubble_ex),
        .bubble_wb         (bubble_wb),
        .mem_timeout       (mem_timeout),
        .ctrl_state        (ctrl_state)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic rs_en,
                          input logic rt_en, input logic ld, input logic [4:0] wa,
                          input logic redir, input logic req, input logic rdy);
        id_rs = rs; id_rt = rt; id_rs_read_en = rs_en; id_rt_read_en = rt_en;
        ex_mem_read_en = ld; ex_reg_write_addr = wa;
        ex_redirect = redir; mem_req = req; mem_ready = rdy;
    endtask

    task automatic idle();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // one clock: compare mid-cycle against the model, then advance the model
    task automatic tick(input string tag);
        logic [6:0] exp_out;
        logic [6:0] obs_out;
        int         exp_state;
        bit         exp_to;
        bit         lu;
        @(negedge clk);
        exp_out = 7'b0000000;
        if (!rst) begin
            m_wait = 1'b0; m_flush = 0; m_low = 0; m_to = 1'b0;
            exp_out   = 7'b0000111;
            exp_state = 0;
            exp_to    = 1'b0;
        end else begin
            lu = ex_mem_read_en && (ex_reg_write_addr != 5'd0) &&
                 ((id_rs_read_en && id_rs == ex_reg_write_addr) ||
                  (id_rt_read_en && id_rt == ex_reg_write_addr));
            exp_state = m_wait ? 1 : ((m_flush > 0) ? 2 : 0);
            exp_to    = m_to;
            if (m_wait) begin
                exp_out = 7'b1111001;
                if (mem_ready) begin
                    m_wait = 1'b0;
                    m_low  = 0;
                end else begin
                    if (m_low < MAXW) m_low++;
                    if (m_low == MAXW) m_to = 1'b1;
                end
            end else if (mem_req && !mem_ready) begin
                exp_out = 7'b1111001;
                m_wait  = 1'b1;
                m_low   = 1;
                if (m_low >= MAXW) m_to = 1'b1;
            end else if (ex_redirect) begin
                exp_out = 7'b0000110;
                m_flush = PEN - 1;
            end else if (m_flush > 0) begin
                exp_out = 7'b0000100;
                m_flush--;
            end else if (lu) begin
                exp_out = 7'b1100010;
            end
        end
        obs_out = {stall_if, stall_id, stall_ex, stall_mem, bubble_id, bubble_ex, bubble_wb};
        check_eq({tag, "/ctl"}, 32'(obs_out), 32'(exp_out));
        check_eq({tag, "/state"}, 32'(ctrl_state), 32'(exp_state));
        check_eq({tag, "/timeout"}, 32'(mem_timeout), 32'(exp_to));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        repeat (3) tick("reset");
        rst = 1'b1;
        tick("first_run");

        set_in(5'd8, 5'd3, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
        tick("lu_rs8");
        idle();
        tick("lu_clear");
        set_in(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        tick("lu_dst0");
        set_in(5'd1, 5'd9, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
        tick("lu_rt9");
        idle();

        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        tick("redir");
        set_in(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
        tick("redir_lu_ignored");
        idle();
        tick("redir_done");

        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        repeat (4) tick("memwait");
        mem_ready = 1'b1;
        tick("memwait_ready");
        idle();
        tick("memwait_done");

        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        repeat (20) tick("timeout");
        mem_ready = 1'b1;
        tick("timeout_ready");
        idle();
        repeat (2) tick("timeout_sticky");

        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        tick("wf_redir");
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        repeat (3) tick("wf_wait");
        mem_ready = 1'b1;
        tick("wf_ready");
        idle();
        repeat (2) tick("wf_resume");

        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        repeat (2) tick("rst_mid_wait");
        rst = 1'b0;
        repeat (2) tick("rst_held");
        rst = 1'b1;
        idle();
        tick("rst_released");

        for (int i = 0; i < 500; i++) begin
            rst               = ($urandom_range(0, 149) != 0);
            id_rs             = 5'($urandom_range(0, 3));
            id_rt             = 5'($urandom_range(0, 3));
            id_rs_read_en     = 1'($urandom_range(0, 1));
            id_rt_read_en     = 1'($urandom_range(0, 1));
            ex_mem_read_en    = ($urandom_range(0, 2) != 0);
            ex_reg_write_addr = 5'($urandom_range(0, 3));
            ex_redirect       = ($urandom_range(0, 7) == 0);
            mem_req           = ($urandom_range(0, 5) == 0) || m_wait;
            mem_ready         = ($urandom_range(0, 2) == 0);
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage MIPS32 pipeline.
- Generates the per-stage stall and bubble signals consumed by the fetch, decode, execute, memory and write-back registers, including the decoder's stall/bubble inputs.
- Handles three events: load-use data hazards, taken-branch/jump squashing, and multi-cycle data-memory waits.
- Contains a small FSM with a flush counter and a memory-wait timeout counter.

Parameters:
- REG_ADDR_W, 5, register address width (matches `REG_ADDR_W).
- BRANCH_PENALTY, 2, cycles squashed after a taken branch/jump resolves in EX; legal range 1..3.
- MAX_MEM_WAIT, 15, maximum consecutive memory-wait cycles before a timeout is flagged.
- CNT_W, 32, perf counter width (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (reset asserted when rst==0).
- id_rs, id_rt  in  REG_ADDR_W  source registers of the instruction in ID.
- id_rs_read_en, id_rt_read_en  in  1  ID source-read enables.
- ex_mem_read_en  in  1  instruction in EX is a load.
- ex_reg_write_addr  in  REG_ADDR_W  destination register of the instruction in EX.
- ex_redirect  in  1  taken branch or jump resolved in EX this cycle.
- mem_req  in  1  MEM stage has an outstanding data access.
- mem_ready  in  1  data memory completes the access this cycle.
- stall_if, stall_id, stall_ex, stall_mem  out  1  hold the named stage register.
- bubble_id, bubble_ex, bubble_wb  out  1  load a NOP into the named stage register.
- mem_timeout  out  1  sticky flag: a memory wait exceeded MAX_MEM_WAIT.
- ctrl_state  out  2  current FSM state, for debug.

Behaviour:
- Outputs are combinational from the registered state and the current inputs, so they are valid before the next rising edge. State and counters update on posedge clk.
- Reset (rst==0):
  - state=RUN, flush_cnt=0, wait_cnt=0, mem_timeout=0.
  - All stall_* = 0.
  - bubble_id = bubble_ex = bubble_wb = 1, so the pipe is flushed.
  - Reset asserted mid-wait or mid-flush aborts immediately, with no residual stall after release.
- States: RUN=0, MEM_WAIT=1, FLUSH=2; 3 is illegal and recovers to RUN.
- Load-use hazard (lu), evaluated combinationally:
  - lu = ex_mem_read_en && ex_reg_write_addr!=0 && ((id_rs_read_en && id_rs==ex_reg_write_addr) || (id_rt_read_en && id_rt==ex_reg_write_addr)).
- Event priority: memory wait > redirect/flush > load-use.
- RUN:
  - mem_req && !mem_ready: assert all four stalls and bubble_wb in that same cycle; wait_cnt<=1; next state MEM_WAIT.
  - Else ex_redirect: bubble_id=1 and bubble_ex=1; flush_cnt<=BRANCH_PENALTY-1; next state FLUSH if that value >0, otherwise RUN.
  - Else lu: stall_if=1, stall_id=1, bubble_ex=1 for one cycle; stay in RUN. The hazard clears itself next cycle.
  - Otherwise all outputs are 0.
- MEM_WAIT:
  - All stalls and bubble_wb stay asserted. ex_redirect and lu are ignored, because EX is frozen and both are re-evaluated after the wait.
  - If mem_ready: the stalls are still asserted this cycle, the data is captured at this edge, and next state is RUN.
  - Otherwise wait_cnt increments, saturating.
  - When wait_cnt reaches MAX_MEM_WAIT, set mem_timeout=1; it stays set until reset. The controller keeps waiting.
- FLUSH:
  - bubble_id=1; lu is ignored because the ID instruction is squashed.
  - flush_cnt decrements each cycle; at 0, next state is RUN.
  - A memory wait arising in FLUSH takes priority: stalls assert and flush_cnt is frozen. The controller returns to FLUSH after mem_ready (saved return state).
  - A new ex_redirect in FLUSH reloads flush_cnt.
- Simultaneous mem_req && mem_ready in RUN is a single-cycle access: no stall.

Optional Feature:
- Macro PIPE_PERF_CNT_EN.
- When defined, add outputs perf_lu_stalls, perf_flush_cycles and perf_mem_wait_cycles (each CNT_W bits). Each counts cycles spent in its condition, is cleared by reset, and wraps at 2^CNT_W.
- When undefined, these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Add to defines.v: state encodings CTRL_RUN, CTRL_MEM_WAIT, CTRL_FLUSH, plus CTRL_STATE_W=2.
- One natural sub-module, hazard_detect: the purely combinational lu comparator, reusable for forwarding checks later.

Test Plan:
- Reset release: rst=0 for 3 cycles, then 1 -> bubbles=1 and stalls=0 during reset; all outputs 0 in the first RUN cycle.
- Load-use: EX has a load to $8, ID reads rs=$8 -> exactly one cycle of stall_if=stall_id=bubble_ex=1. Same scenario with destination $0 -> no stall.
- Redirect with BRANCH_PENALTY=2: ex_redirect pulse -> bubble_id=1 for 2 cycles and bubble_ex=1 in the first. An lu asserted in the second cycle produces no stall.
- Memory wait: mem_req=1 with mem_ready low for 4 cycles -> all stalls plus bubble_wb held for 5 cycles, then RUN; mem_timeout stays 0.
- Timeout: mem_ready held low for 20 cycles with MAX_MEM_WAIT=15 -> mem_timeout rises at the 15th wait cycle and stays set after mem_ready and after the return to RUN.
- Wait inside flush: ex_redirect, then mem_req stalls 3 cycles on the next cycle -> the flush resumes with its remaining count and finishes after the wait.
